button_conditioner: RTL and testbench
=====================================

# button_conditioner

Parametrised multi-channel input conditioner for board push-buttons and switches, the successor to the single-function debouncer feeding the button PIO. Per channel: two-flop synchroniser, consecutive-sample debounce, polarity normalisation, and one-cycle press/release/long-press event pulses plus a press-toggle latch. It sits between the raw KEY/SW pins and the PIO/IRQ logic in the kernel interface, in the 50 MHz board clock domain.

## Interface

- WIDTH, 2, number of independent channels
- POLARITY, "LOW", active level of data_in: "LOW" or "HIGH"
- TIMEOUT, 50000, consecutive disagreeing samples needed to accept a change (>=1; 1 ms at 50 MHz)
- TIMEOUT_WIDTH, 16, debounce counter width, >= ceil(log2(TIMEOUT))
- LONG_TIMEOUT, 50000000, cycles of stable pressed state before long_press (>=1)
- LONG_WIDTH, 26, hold counter width, >= ceil(log2(LONG_TIMEOUT))

Ports:

- clk  in  1  board clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- data_in  in  WIDTH  raw asynchronous pin levels
- data_out  out  WIDTH  debounced state, normalised to 1 = pressed
- press  out  WIDTH  one-cycle pulse on accepted press
- release  out  WIDTH  one-cycle pulse on accepted release
- long_press  out  WIDTH  one-cycle pulse, at most once per press
- toggle  out  WIDTH  flips on each accepted press

## Operation

- Channels are fully independent and identical; each has its own counters.
- Normalisation: n = data_in when POLARITY is "HIGH", otherwise ~data_in. It is applied before the synchroniser.
- Synchroniser: sync1 <= n, then s <= sync1.
- Debounce counter cnt, TIMEOUT_WIDTH bits, and stable state st drive data_out. On each edge:
  - If s == st: cnt <= 0.
  - Else if cnt == TIMEOUT-1: st <= s, cnt <= 0, and fire press (s=1) or release (s=0).
  - Else: cnt <= cnt+1.
  - Any agreeing sample restarts the count, so glitches shorter than TIMEOUT cycles are fully rejected.
- Hold logic uses counter hc (LONG_WIDTH bits) and flag fired.
  - On each edge with st==1 and fired==0: if hc == LONG_TIMEOUT-1, pulse long_press, set fired, and hold hc; otherwise hc <= hc+1.
  - When st==1 and fired==1, hc holds.
  - On accepted release: hc <= 0, fired <= 0.
  - Release has priority: if the release-accept edge coincides with hc == LONG_TIMEOUT-1, no long_press is issued.
- Toggle: toggle <= ~toggle on the press-pulse edge.
- All outputs are registered; pulses deassert on the following edge.

## Timing

- Reset (asynchronous, active-high) clears data_out, press, release, long_press, toggle, cnt, hc and fired to 0.
  - sync1 and s reset to 0, which is the released level after normalisation.
  - A pin held pressed through reset is therefore accepted as a fresh press TIMEOUT+2 edges after reset release.
- Reset asserted mid-count or mid-hold aborts the operation. No pulse is emitted on or after reset assertion.
- Latency: when a pin changes before edge 1 and then stays stable:
  - Edge 1 samples sync1 and edge 2 samples s.
  - Edges 3..TIMEOUT+2 count.
  - data_out and the press/release pulse update on edge TIMEOUT+2. With TIMEOUT=1 this is edge 3.
- Long press: the first counting edge is TIMEOUT+3. long_press asserts after edge TIMEOUT+2+LONG_TIMEOUT, for exactly one cycle.
- press and release are never both high in one channel in the same cycle. long_press never coincides with press.
- Counters never wrap. cnt is bounded by TIMEOUT-1 and hc by LONG_TIMEOUT-1.

## Test plan

Run with TIMEOUT=4, LONG_TIMEOUT=10, WIDTH=2 unless stated.

- Reset, then POLARITY="LOW" with data_in=2'b11 held: all outputs stay 0 indefinitely.
- Channel 0 pin driven 1→0 before edge 1 and held: data_out[0]=1 and press[0]=1 after edge 6, press[0]=0 after edge 7, toggle[0]=1. Channel 1 is unaffected.
- Channel 0 pin pulses low for 3 cycles and then returns high, repeated 5 times: no data_out change and no pulses. A 4-cycle low is accepted.
- Press held: long_press[0] is a single pulse after edge 16 (6+10). Holding 100 more cycles gives no further pulse. Release gives release[0] 6 edges after the pin change, and data_out[0]=0.
- Release accepted on the same edge hc reaches 9 (release pin change timed so acceptance lands on edge 16): release[0]=1 and long_press[0] stays 0. The next press gives a full 10-cycle hold.
- Reset asserted at cnt=2 mid-press: outputs are 0 immediately (asynchronously). If the pin is still pressed after reset release, press[0] arrives exactly 6 edges later. Repeat with POLARITY="HIGH" and TIMEOUT=1: press arrives on edge 3.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button/switch conditioner: synchroniser, debounce, polarity
// normalisation, press/release/long-press pulses and a press-toggle latch per channel.
module button_conditioner #(
   parameter int    WIDTH         = 2,
   parameter string POLARITY      = "LOW",
   parameter int    TIMEOUT       = 50000,
   parameter int    TIMEOUT_WIDTH = 16,
   parameter int    LONG_TIMEOUT  = 50000000,
   parameter int    LONG_WIDTH    = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] long_press,
   output logic [WIDTH-1:0] toggle
);

   localparam bit                     ACTIVE_HIGH = (POLARITY == "HIGH");
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);
   localparam logic [LONG_WIDTH-1:0]    HOLD_LAST = LONG_WIDTH'(LONG_TIMEOUT - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] st_q, st_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;
   logic [WIDTH-1:0] long_q, long_d;
   logic [WIDTH-1:0] toggle_q, toggle_d;
   logic [WIDTH-1:0] fired_q, fired_d;
   logic [WIDTH-1:0][TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0][LONG_WIDTH-1:0]    hc_q, hc_d;

   always_comb begin
      // Normalise before synchronising so the reset value 0 means "released".
      sync1_d   = ACTIVE_HIGH ? data_in : ~data_in;
      s_d       = sync1_q;
      st_d      = st_q;
      cnt_d     = cnt_q;
      hc_d      = hc_q;
      fired_d   = fired_q;
      toggle_d  = toggle_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s_q[i] == st_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]      = s_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = s_q[i];
            release_d[i] = ~s_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + TIMEOUT_WIDTH'(1);
         end

         // An accepted release wins over a long-press landing on the same edge.
         if (release_d[i]) begin
            hc_d[i]    = '0;
            fired_d[i] = 1'b0;
         end else if (st_q[i] && !fired_q[i]) begin
            if (hc_q[i] == HOLD_LAST) begin
               long_d[i]  = 1'b1;
               fired_d[i] = 1'b1;
            end else begin
               hc_d[i] = hc_q[i] + LONG_WIDTH'(1);
            end
         end

         if (press_d[i]) toggle_d[i] = ~toggle_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         s_q       <= '0;
         st_q      <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         toggle_q  <= '0;
         fired_q   <= '0;
         cnt_q     <= '0;
         hc_q      <= '0;
      end else begin
         sync1_q   <= sync1_d;
         s_q       <= s_d;
         st_q      <= st_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         toggle_q  <= toggle_d;
         fired_q   <= fired_d;
         cnt_q     <= cnt_d;
         hc_q      <= hc_d;
      end
   end

   assign data_out      = st_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign toggle        = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one active-low TIMEOUT=4 instance driven from a vector
// table, and one active-high TIMEOUT=1 instance for the reset/latency corner cases.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rst_b = 1'b1;
   logic [1:0] data_in = 2'b11;
   logic [1:0] data_in_b = 2'b00;
   logic [1:0] do_a, pr_a, rl_a, lp_a, tg_a;
   logic [1:0] do_b, pr_b, rl_b, lp_b, tg_b;
   logic [9:0] outs_a, outs_b;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0] din;
      int         n;
      logic [9:0] e;
   } vec_t;

   vec_t       tbl[$];
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   button_conditioner #(
      .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(4), .TIMEOUT_WIDTH(2),
      .LONG_TIMEOUT(10), .LONG_WIDTH(4)
   ) dut_a (
      .clk(clk), .reset(reset), .data_in(data_in),
      .data_out(do_a), .press(pr_a), .release_pulse(rl_a),
      .long_press(lp_a), .toggle(tg_a)
   );

   button_conditioner #(
      .WIDTH(2), .POLARITY("HIGH"), .TIMEOUT(1), .TIMEOUT_WIDTH(1),
      .LONG_TIMEOUT(10), .LONG_WIDTH(4)
   ) dut_b (
      .clk(clk), .reset(rst_b), .data_in(data_in_b),
      .data_out(do_b), .press(pr_b), .release_pulse(rl_b),
      .long_press(lp_b), .toggle(tg_b)
   );

   assign outs_a = {do_a, pr_a, rl_a, lp_a, tg_a};
   assign outs_b = {do_b, pr_b, rl_b, lp_b, tg_b};

   function automatic logic [9:0] ev(input logic [1:0] d, input logic [1:0] p,
                                     input logic [1:0] r, input logic [1:0] l,
                                     input logic [1:0] t);
      return {d, p, r, l, t};
   endfunction

   task automatic check(input string nm, input logic [9:0] got, input logic [9:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got {do,pr,rl,lp,tg}=%b required %b", nm, got, exp);
      end
   endtask

   task automatic add(input logic [1:0] din, input int n, input logic [1:0] d,
                      input logic [1:0] p, input logic [1:0] r, input logic [1:0] l,
                      input logic [1:0] t);
      vec_t v;
      v.din = din;
      v.n   = n;
      v.e   = ev(d, p, r, l, t);
      tbl.push_back(v);
   endtask

   // Starts and ends just after a falling edge; each iteration is one rising edge.
   task automatic apply(input bit b, input logic [1:0] din, input int n,
                        input logic [9:0] e, input string nm);
      logic [9:0] exp;
      for (int i = 0; i < n; i++) begin
         if (b) data_in_b = din;
         else   data_in   = din;
         sb.push_back(e);
         @(posedge clk);
         #1;
         exp = sb.pop_front();
         check($sformatf("%s[%0d]", nm, i), b ? outs_b : outs_a, exp);
         @(negedge clk);
      end
   endtask

   initial begin
      // idle, pins released (active low)
      add(2'b11, 30, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // ch0 press, long press at edge 16, 100 more held cycles
      add(2'b10, 5,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b10, 1,   2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
      add(2'b10, 9,   2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b10, 1,   2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
      add(2'b10, 100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      // release
      add(2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
      add(2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      // five 3-cycle glitches rejected
      for (int k = 0; k < 5; k++) begin
         add(2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
         add(2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      end
      // 4-cycle low accepted, then released
      add(2'b10, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b11, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      add(2'b11, 3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add(2'b11, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // release accepted on the edge where hc would hit its last value
      add(2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
      add(2'b10, 4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
      add(2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      // next press gets a full hold
      add(2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
      add(2'b10, 9, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
      add(2'b10, 3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
      add(2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // both channels together
      add(2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
      add(2'b00, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
      add(2'b11, 5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
      add(2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
      add(2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);

      repeat (2) @(posedge clk);
      #1;
      check("reset_a", outs_a, 10'd0);
      check("reset_b", outs_b, 10'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[k]) apply(1'b0, tbl[k].din, tbl[k].n, tbl[k].e, $sformatf("vec%0d", k));

      // reset mid-count (cnt=2) with toggle set; pin stays pressed through reset
      apply(1'b0, 2'b10, 4, ev(2'b00, 2'b00, 2'b00, 2'b00, 2'b11), "pre_rst");
      reset = 1'b1;
      #1;
      check("async_rst_a", outs_a, 10'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_a", outs_a, 10'd0);
      @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 2'b10, 5, ev(2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "rst_cnt");
      apply(1'b0, 2'b10, 1, ev(2'b01, 2'b01, 2'b00, 2'b00, 2'b01), "rst_press");
      apply(1'b0, 2'b10, 1, ev(2'b01, 2'b00, 2'b00, 2'b00, 2'b01), "rst_after");

      // active-high, TIMEOUT=1: press on edge 3 after reset release
      data_in_b = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      check("b_rst_hold", outs_b, 10'd0);
      @(negedge clk);
      rst_b = 1'b0;
      apply(1'b1, 2'b01, 2, ev(2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "b_sync");
      apply(1'b1, 2'b01, 1, ev(2'b01, 2'b01, 2'b00, 2'b00, 2'b01), "b_press");
      apply(1'b1, 2'b01, 1, ev(2'b01, 2'b00, 2'b00, 2'b00, 2'b01), "b_hold");
      rst_b = 1'b1;
      #1;
      check("b_async_rst", outs_b, 10'd0);
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      apply(1'b1, 2'b01, 2, ev(2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "b_sync2");
      apply(1'b1, 2'b01, 1, ev(2'b01, 2'b01, 2'b00, 2'b00, 2'b01), "b_press2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
